sram_prog_writer: RTL and testbench

//  Writes a program image into the external asynchronous SRAM that new_ts later reads

---
 rtl/gpu_mem_pkg.sv | 24 ++
 rtl/prog_word_fifo.sv | 55 +++++
 rtl/sram_prog_writer.sv | 213 +++++++++++++++++++++
 tb/tb_sram_prog_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types for the program-image SRAM writer: FSM state encoding, SRAM widths
// and the FIFO entry layout.
package gpu_mem_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE,
        ST_RD_SETUP,
        ST_RD_CMP
    } writer_state_t;

    typedef struct packed {
        logic                   last;
        logic [SRAM_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/prog_word_fifo.sv
// Small synchronous FIFO holding program words plus their last flag; DEPTH must be a
// power of two (>= 2). Flush empties it in one cycle.
module prog_word_fifo
    import gpu_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t rd_entry,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t    mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_entry = mem[rd_ptr[PTR_W-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
        end
    end

endmodule

// File: rtl/sram_prog_writer.sv
// Streams a program image into asynchronous SRAM with setup/pulse/hold WE_N timing.
// Optional readback check of every word is enabled by defining SRAM_READBACK_VERIFY_EN.
//
// state     | meaning
// IDLE      | no load since reset
// WAIT      | load active, waiting for a buffered word
// SETUP     | address/data/CE driven, WE_N high
// PULSE     | WE_N low for WE_CYCLES cycles
// HOLD      | WE_N high, data still driven
// RD_SETUP  | (verify) DQ released, OE_N low
// RD_CMP    | (verify) compare pad data with the word written
// DONE      | image complete, load_done high
module sram_prog_writer
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2,
    parameter int MAX_WORDS  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W-1:0] word_count,
    output logic              err_overflow,
    output logic              err_verify
);

    localparam int              PW    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WORDS);

    writer_state_t     state;
    logic [PW-1:0]     pulse_cnt;
    logic              cur_last;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              word_end;
    logic              at_decision;
    logic              discard;
    logic [ADDR_W-1:0] cnt_eff;

`ifdef SRAM_READBACK_VERIFY_EN
    logic [DATA_W-1:0] cur_data;
    logic              oe_n_q;
    logic              err_verify_q;
    assign sram_oe_n  = oe_n_q;
    assign err_verify = err_verify_q;
    assign word_end   = (state == ST_RD_CMP);
`else
    logic unused_dq_in;
    assign unused_dq_in = ^sram_dq_in;
    assign sram_oe_n    = 1'b1;
    assign err_verify   = 1'b0;
    assign word_end     = (state == ST_HOLD);
`endif

    assign busy            = (state != ST_IDLE) && (state != ST_DONE);
    assign in_ready        = busy && !fifo_full;
    assign fifo_push       = in_valid && in_ready;
    assign fifo_flush      = start && !busy;
    assign push_entry.last = in_last;
    assign push_entry.data = in_data;

    // word_count bumps at the end of HOLD, so decisions taken there see the new count.
    assign cnt_eff     = (state == ST_HOLD) ? word_count + ADDR_W'(1) : word_count;
    assign at_decision = (state == ST_WAIT) || word_end;
    assign fifo_pop    = at_decision && !(word_end && cur_last) && !fifo_empty;
    assign discard     = (cnt_eff >= MAX_W);

    prog_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .wr_entry (push_entry),
        .pop      (fifo_pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pulse_cnt    <= '0;
            cur_last     <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_lb_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
            load_done    <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
`ifdef SRAM_READBACK_VERIFY_EN
            cur_data     <= '0;
            oe_n_q       <= 1'b1;
            err_verify_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_WAIT;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
                        load_done    <= 1'b0;
`ifdef SRAM_READBACK_VERIFY_EN
                        err_verify_q <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    state     <= ST_PULSE;
                    sram_we_n <= 1'b0;
                    pulse_cnt <= PW'(WE_CYCLES - 1);
                end
                ST_PULSE: begin
                    if (pulse_cnt == '0) begin
                        state     <= ST_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                ST_HOLD: begin
                    word_count <= word_count + ADDR_W'(1);
`ifdef SRAM_READBACK_VERIFY_EN
                    state      <= ST_RD_SETUP;
                    sram_dq_oe <= 1'b0;
                    oe_n_q     <= 1'b0;
`endif
                end
`ifdef SRAM_READBACK_VERIFY_EN
                ST_RD_SETUP: begin
                    state <= ST_RD_CMP;
                end
                ST_RD_CMP: begin
                    oe_n_q <= 1'b1;
                    if (sram_dq_in != cur_data) begin
                        err_verify_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase

            // Shared next-word dispatch for WAIT and the final cycle of each write.
            if (at_decision) begin
                if ((word_end && cur_last) || (fifo_pop && discard && head.last)) begin
                    state      <= ST_DONE;
                    sram_ce_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    load_done  <= 1'b1;
                    if (fifo_pop) begin
                        err_overflow <= 1'b1;
                    end
                end else if (fifo_pop && !discard) begin
                    state       <= ST_SETUP;
                    sram_addr   <= cnt_eff;
                    sram_dq_out <= head.data;
                    sram_dq_oe  <= 1'b1;
                    sram_ce_n   <= 1'b0;
                    sram_lb_n   <= 1'b0;
                    sram_ub_n   <= 1'b0;
                    sram_we_n   <= 1'b1;
                    cur_last    <= head.last;
`ifdef SRAM_READBACK_VERIFY_EN
                    cur_data    <= head.data;
`endif
                end else begin
                    state      <= ST_WAIT;
                    sram_ce_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    if (fifo_pop) begin
                        err_overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_prog_writer.sv
// Bench for sram_prog_writer: two instances (large and 4-word image limit), an SRAM
// model that captures writes, and a per-cycle strobe timing checker.
module tb_sram_prog_writer;

    localparam int WE  = 2;
`ifdef SRAM_READBACK_VERIFY_EN
    localparam int CPW = 4 + WE;
`else
    localparam int CPW = 2 + WE;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start     [2];
    logic        in_valid  [2];
    logic        in_last   [2];
    logic [15:0] in_data   [2];
    logic        in_ready  [2];
    logic [19:0] sram_addr [2];
    logic [15:0] dq_out    [2];
    logic [15:0] dq_in     [2];
    logic        dq_oe     [2];
    logic        ce_n      [2];
    logic        we_n      [2];
    logic        oe_n      [2];
    logic        lb_n      [2];
    logic        ub_n      [2];
    logic        busy      [2];
    logic        load_done [2];
    logic [19:0] word_count[2];
    logic        err_ovf   [2];
    logic        err_ver   [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          max_w [2] = '{1024, 4};

    logic [15:0] mem [2][64];
    logic [15:0] rd_mask = 16'hFFFF;
    logic [15:0] tx [$];
    logic [15:0] acc_q [$];
    int          stalls;
    int          wr_cnt [2];
    int          last_fall [2];
    int          min_iv [2];
    int          max_iv [2];
    int          cyc = 0;
    logic [19:0] prev_addr [2];
    logic [15:0] prev_dq [2];
    logic        prev_we [2] = '{1'b1, 1'b1};
    logic        prev_ce [2] = '{1'b1, 1'b1};
    int          plen [2] = '{0, 0};

    always #10 clk = ~clk;

    assign dq_in[0] = mem[0][sram_addr[0][5:0]] & rd_mask;
    assign dq_in[1] = mem[1][sram_addr[1][5:0]] & rd_mask;

    sram_prog_writer #(.FIFO_DEPTH(4), .WE_CYCLES(WE), .MAX_WORDS(1024)) u_big (
        .clk(clk), .reset(reset), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]),
        .sram_dq_in(dq_in[0]), .sram_ce_n(ce_n[0]), .sram_we_n(we_n[0]),
        .sram_oe_n(oe_n[0]), .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]),
        .busy(busy[0]), .load_done(load_done[0]), .word_count(word_count[0]),
        .err_overflow(err_ovf[0]), .err_verify(err_ver[0]));

    sram_prog_writer #(.FIFO_DEPTH(4), .WE_CYCLES(WE), .MAX_WORDS(4)) u_small (
        .clk(clk), .reset(reset), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]),
        .sram_dq_in(dq_in[1]), .sram_ce_n(ce_n[1]), .sram_we_n(we_n[1]),
        .sram_oe_n(oe_n[1]), .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]),
        .busy(busy[1]), .load_done(load_done[1]), .word_count(word_count[1]),
        .err_overflow(err_ovf[1]), .err_verify(err_ver[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Strobe timing rules and SRAM write capture, every cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                prev_we[i] = 1'b1;
                prev_ce[i] = 1'b1;
                plen[i]    = 0;
                continue;
            end
            if (!we_n[i]) begin
                if (prev_we[i]) begin
                    chk("setup_before_pulse_ce", prev_ce[i], 1'b0);
                    chk("write_addr_sequential", sram_addr[i], wr_cnt[i]);
                    if (last_fall[i] >= 0) begin
                        if (cyc - last_fall[i] < min_iv[i]) min_iv[i] = cyc - last_fall[i];
                        if (cyc - last_fall[i] > max_iv[i]) max_iv[i] = cyc - last_fall[i];
                    end
                    last_fall[i] = cyc;
                end
                chk("pulse_addr_stable", sram_addr[i], prev_addr[i]);
                chk("pulse_data_stable", dq_out[i], prev_dq[i]);
                chk("pulse_ce_low", ce_n[i], 1'b0);
                chk("pulse_dq_oe", dq_oe[i], 1'b1);
                chk("pulse_byte_en", {lb_n[i], ub_n[i]}, 2'b00);
                chk("pulse_oe_high", oe_n[i], 1'b1);
                plen[i]++;
            end else if (!prev_we[i]) begin
                chk("we_pulse_width", plen[i], WE);
                chk("hold_addr_stable", sram_addr[i], prev_addr[i]);
                chk("hold_data_stable", dq_out[i], prev_dq[i]);
                chk("hold_dq_oe", dq_oe[i], 1'b1);
                chk("hold_ce_low", ce_n[i], 1'b0);
                mem[i][sram_addr[i][5:0]] = dq_out[i];
                wr_cnt[i]++;
                plen[i] = 0;
            end
            chk("ready_implies_busy", in_ready[i] && !busy[i], 1'b0);
`ifndef SRAM_READBACK_VERIFY_EN
            chk("oe_n_constant", oe_n[i], 1'b1);
`endif
            prev_addr[i] = sram_addr[i];
            prev_dq[i]   = dq_out[i];
            prev_we[i]   = we_n[i];
            prev_ce[i]   = ce_n[i];
        end
    end

    task automatic do_start(input int i);
        for (int k = 0; k < 64; k++) mem[i][k] = 16'hDEAD;
        wr_cnt[i]    = 0;
        last_fall[i] = -1;
        min_iv[i]    = 1000;
        max_iv[i]    = 0;
        acc_q.delete();
        stalls = 0;
        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic send(input int i);
        logic ok;
        int   waitc;
        for (int k = 0; k < tx.size(); k++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = tx[k];
            in_last[i]  = (k == tx.size() - 1);
            waitc = 0;
            forever begin
                @(negedge clk);
                ok = in_ready[i];
                if (!ok) stalls++;
                @(posedge clk); #1;
                if (ok) break;
                waitc++;
                if (waitc > 100) begin
                    timeout("send_handshake");
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                    return;
                end
            end
            acc_q.push_back(tx[k]);
        end
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (load_done[i]) return;
        end
        timeout("wait_load_done");
    endtask

    // Expected image: the first min(accepted, MAX_WORDS) accepted words, in order.
    task automatic check_load(input int i);
        int nw;
        nw = (acc_q.size() < max_w[i]) ? acc_q.size() : max_w[i];
        chk("load_done", load_done[i], 1'b1);
        chk("busy_after_done", busy[i], 1'b0);
        chk("word_count", word_count[i], nw);
        chk("writes_seen", wr_cnt[i], nw);
        chk("err_overflow", err_ovf[i], acc_q.size() > max_w[i]);
        chk("err_verify_clean", err_ver[i], 1'b0);
        chk("strobes_idle", {ce_n[i], we_n[i], lb_n[i], ub_n[i], dq_oe[i]}, 5'b11110);
        for (int k = 0; k < nw; k++) chk("image_word", mem[i][k], acc_q[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; in_last[i] = 1'b0; in_data[i] = '0;
            wr_cnt[i] = 0; last_fall[i] = -1; min_iv[i] = 1000; max_iv[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_strobes", {ce_n[i], we_n[i], oe_n[i], lb_n[i], ub_n[i]}, 5'b11111);
            chk("rst_dq_oe", dq_oe[i], 1'b0);
            chk("rst_addr", sram_addr[i], 0);
            chk("rst_dq_out", dq_out[i], 0);
            chk("rst_flags", {in_ready[i], busy[i], load_done[i], err_ovf[i], err_ver[i]}, 5'b0);
            chk("rst_word_count", word_count[i], 0);
        end
        reset = 1'b0;

        // three-word image
        do_start(0);
        tx = '{16'h1111, 16'h2222, 16'h3333};
        send(0);
        wait_done(0);
        check_load(0);
        chk("lit_mem0", mem[0][0], 16'h1111);
        chk("lit_mem1", mem[0][1], 16'h2222);
        chk("lit_mem2", mem[0][2], 16'h3333);
        chk("lit_count3", word_count[0], 3);
        chk("cycles_per_word_min", min_iv[0], CPW);
        chk("cycles_per_word_max", max_iv[0], CPW);

        // continuous stream of eight words against a four-deep buffer
        do_start(0);
        tx = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4, 16'hA5A5, 16'hA6A6, 16'hA7A7};
        send(0);
        chk("backpressure_seen", stalls > 0, 1'b1);
        chk("accepted_count8", acc_q.size(), 8);
        wait_done(0);
        check_load(0);
        chk("lit_mem7", mem[0][7], 16'hA7A7);
        chk("stream_cpw_max", max_iv[0], CPW);

        // overflow beyond a four-word limit
        do_start(1);
        tx = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06};
        send(1);
        wait_done(1);
        check_load(1);
        chk("lit_ovf_count", word_count[1], 4);
        chk("lit_ovf_last_write", mem[1][3], 16'h0B04);
        chk("lit_ovf_flag", err_ovf[1], 1'b1);

        // restarting clears the sticky overflow
        do_start(1);
        tx = '{16'h0C01, 16'h0C02};
        send(1);
        wait_done(1);
        check_load(1);

        // reset in the middle of a write pulse
        do_start(0);
        tx = '{16'h5A5A};
        send(0);
        begin : find_pulse
            for (int c = 0; c < 40; c++) begin
                if (!we_n[0]) disable find_pulse;
                @(posedge clk); #1;
            end
            timeout("find_we_pulse");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we_ce", {we_n[0], ce_n[0]}, 2'b11);
        chk("midrst_dq_oe", dq_oe[0], 1'b0);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_count", word_count[0], 0);
        reset = 1'b0;

`ifdef SRAM_READBACK_VERIFY_EN
        // readback against a pad with bit 0 stuck low
        rd_mask = 16'hFFFE;
        do_start(0);
        tx = '{16'h0001};
        send(0);
        wait_done(0);
        chk("verify_mismatch_flag", err_ver[0], 1'b1);
        rd_mask = 16'hFFFF;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
